mem_stage_dcache: RTL

MEM_STAGE_DCACHE -- requirements
Module: mem_stage_dcache

---
 rtl/mem_stage_dcache.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, one 32-bit word per line.
// Write-through with no write-allocate. Loads are extended to 32 bits and stores are lane-replicated.
// A miss or any store freezes the pipeline until the backing memory answers.
module mem_stage_dcache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  addr_mode,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [31:0]           line_data;
    logic                  hit;
    logic                  is_load;

    logic [31:0] st_lane;
    logic [3:0]  st_strb;
    logic [31:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign idx       = addr[INDEX_BITS+1:2];
    assign tag       = addr[31:INDEX_BITS+2];
    assign line_data = data_mem[idx];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    // A simultaneous store wins, so the load side is ignored whenever mem_write is set.
    assign is_load   = mem_read && !mem_write;

    // Store lane replication and byte strobes; unused modes behave as a word store.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        st_lane = wdata;
        st_strb = 4'b1111;
        case (addr_mode)
            3'b000: begin
                st_lane = {4{wdata[7:0]}};
                st_strb = 4'b0001 << addr[1:0];
            end
            3'b001: begin
                st_lane = {2{wdata[15:0]}};
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Byte-merge the store lanes into the currently cached word.
    always_comb begin
        merged = line_data;
        for (int b = 0; b < 4; b++) begin
            if (st_strb[b]) merged[8*b +: 8] = st_lane[8*b +: 8];
        end
    end

    // Load extraction. Low address bits below the access size are ignored.
    always_comb begin
        case (addr[1:0])
            2'd0:    ld_byte = line_data[7:0];
            2'd1:    ld_byte = line_data[15:8];
            2'd2:    ld_byte = line_data[23:16];
            default: ld_byte = line_data[31:24];
        endcase
        ld_half = addr[1] ? line_data[31:16] : line_data[15:0];
        case (addr_mode)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = line_data;
        endcase
    end

    // Load result is valid on an IDLE hit or in DONE. It is zero otherwise and always zero when no load is requested.
    always_comb begin
        rdata = 32'h0;
        if (is_load && hit && (state == IDLE || state == DONE)) rdata = ld_ext;
    end

    // Pipeline freeze. In IDLE it depends on the live request. A busy transaction holds it high, and DONE releases it.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = mem_write || (mem_read && !hit);
            FILL:    stall = 1'b1;
            WRITE:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Backing-memory request, decoded from the registered state.
    // The address and data inputs are held by the pipeline during the stall, so these outputs stay stable.
    always_comb begin
        mem_req   = (state == FILL) || (state == WRITE);
        mem_we    = (state == WRITE);
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = st_lane;
        mem_wstrb = (state == WRITE) ? st_strb : 4'b0000;
    end

    // Controller FSM and valid bits. Reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
        if (rst) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write)            state <= WRITE;
                    else if (mem_read && !hit) state <= FILL;
                end
                FILL: begin
                    if (mem_ready) begin
                        valid[idx] <= 1'b1;
                        state      <= DONE;
                    end
                end
                WRITE: begin
                    if (mem_ready) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage. Writes are gated by rst so that an abandoned transaction leaves the array untouched.
    always_ff @(posedge clk) begin
        // NOTE: tag and data arrays have no reset. The cleared valid bits alone make their contents unobservable, and this keeps them mappable to RAM.
        if (!rst && state == FILL && mem_ready) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (!rst && state == WRITE && mem_ready && hit) begin
            data_mem[idx] <= merged;
        end
    end

endmodule
